// File: rtl/uart_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl_if
// Purpose : Bundles every non-clock signal of the UART command sequencer.
//           This covers the uart_rx byte strobe, the SDRAM write/read
//           request ports, the uart_tx start/busy handshake and the
//           status outputs.
// Modports: master - the sequencer (drives requests, tx_start, err_flag, busy)
//           slave  - the surrounding system (uart_rx, SDRAM ctrl, uart_tx)
// Signals : po_flag/rx_data          received byte strobe and value
//           wr_req/wr_addr/wr_data   SDRAM write request (level until wr_ack)
//           wr_ack                   write accepted
//           rd_req/rd_addr           SDRAM read request (level until rd_ack)
//           rd_ack                   read accepted
//           rd_valid/rd_data         read data strobe and value
//           tx_start/tx_data         one-cycle transmit strobe and byte
//           tx_busy                  transmitter busy
//           err_flag                 one-cycle error pulse
//           busy                     sequencer not idle
// -----------------------------------------------------------------------------
interface uart_cmd_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              po_flag;
    logic [7:0]        rx_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [7:0]        rd_data;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              err_flag;
    logic              busy;

    modport master (
        input  po_flag, rx_data, wr_ack, rd_ack, rd_valid, rd_data, tx_busy,
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, tx_start, tx_data,
               err_flag, busy
    );

    modport slave (
        output po_flag, rx_data, wr_ack, rd_ack, rd_valid, rd_data, tx_busy,
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, tx_start, tx_data,
               err_flag, busy
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
// Purpose : Collects 4-byte host frames (opcode, addr_hi, addr_lo, data) from
//           uart_rx and issues one SDRAM write or read request per frame.
//           Read data is returned through uart_tx. Bad opcodes and bytes
//           that arrive while a command is in flight (overruns) pulse
//           err_flag once.
// Ports   : clk  - system clock
//           rst  - asynchronous, active-low reset
//           bus  - uart_cmd_ctrl_if.master (see interface file for signals)
// Params  : ADDR_W (>=16), CMD_WR, CMD_RD, TIMEOUT_CYC
// Config  : UART_CMD_TIMEOUT_EN - when defined, a stalled partial frame is
//           abandoned after TIMEOUT_CYC idle cycles with an err_flag pulse.
//           When undefined, a partial frame waits until reset.
// -----------------------------------------------------------------------------
module uart_cmd_ctrl #(
    parameter int         ADDR_W      = 16,
    parameter logic [7:0] CMD_WR      = 8'h55,
    parameter logic [7:0] CMD_RD      = 8'hAA,
    parameter int         TIMEOUT_CYC = 12000
) (
    input  logic            clk,
    input  logic            rst,
    uart_cmd_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_AH  = 3'd1,
        GET_AL  = 3'd2,
        GET_D   = 3'd3,
        WR_REQ  = 3'd4,
        RD_REQ  = 3'd5,
        RD_WAIT = 3'd6,
        TX_WAIT = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic        op_wr_q, op_wr_d;       // 1: frame is a write, 0: a read
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        wr_req_q, wr_req_d;
    logic        rd_req_q, rd_req_d;
    logic        tx_start_q, tx_start_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        tmo_hit_s;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_frame_s;

    // Inter-byte idle counter: runs only while a frame is partially received.
    always_comb begin
        in_frame_s = (state_q == GET_AH) || (state_q == GET_AL) || (state_q == GET_D);
        // An arriving byte wins over an expiring count on the same cycle.
        tmo_hit_s  = in_frame_s && !bus.po_flag && (cnt_q == CNT_LAST);
        if (!in_frame_s || bus.po_flag || tmo_hit_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state and next-output logic of the frame sequencer.
    always_comb begin
        state_d    = state_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.po_flag) begin
                    if ((bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD)) begin
                        op_wr_d = (bus.rx_data == CMD_WR);
                        state_d = GET_AH;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            GET_AH: begin
                if (bus.po_flag) begin
                    addr_d[15:8] = bus.rx_data;
                    state_d      = GET_AL;
                end else if (tmo_hit_s) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = GET_AH;
                end
            end
            GET_AL: begin
                if (bus.po_flag) begin
                    addr_d[7:0] = bus.rx_data;
                    state_d     = GET_D;
                end else if (tmo_hit_s) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = GET_AL;
                end
            end
            GET_D: begin
                if (bus.po_flag) begin
                    data_d  = bus.rx_data;
                    state_d = op_wr_q ? WR_REQ : RD_REQ;
                end else if (tmo_hit_s) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = GET_D;
                end
            end
            // In the four busy states any incoming byte is an overrun: it is
            // dropped and flagged, even when it coincides with a transition.
            WR_REQ: begin
                err_d = bus.po_flag;
                if (bus.wr_ack) begin
                    state_d = IDLE;
                end else begin
                    state_d = WR_REQ;
                end
            end
            RD_REQ: begin
                err_d = bus.po_flag;
                if (bus.rd_ack) begin
                    state_d = RD_WAIT;
                end else begin
                    state_d = RD_REQ;
                end
            end
            RD_WAIT: begin
                err_d = bus.po_flag;
                if (bus.rd_valid) begin
                    tx_data_d = bus.rd_data;
                    state_d   = TX_WAIT;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            TX_WAIT: begin
                err_d = bus.po_flag;
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = TX_WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Requests are derived from the next state so they rise on the edge
        // that accepts the last byte and fall on the edge that samples ack.
        wr_req_d = (state_d == WR_REQ);
        rd_req_d = (state_d == RD_REQ);
        busy_d   = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_wr_q    <= 1'b0;
            addr_q     <= 16'h0000;
            data_q     <= 8'h00;
            tx_data_q  <= 8'h00;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_wr_q    <= op_wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tx_data_q  <= tx_data_d;
            wr_req_q   <= wr_req_d;
            rd_req_q   <= rd_req_d;
            tx_start_q <= tx_start_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    // The frame carries 16 address bits; wider ports are zero-extended.
    assign bus.wr_req   = wr_req_q;
    assign bus.wr_addr  = ADDR_W'(addr_q);
    assign bus.wr_data  = data_q;
    assign bus.rd_req   = rd_req_q;
    assign bus.rd_addr  = ADDR_W'(addr_q);
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.err_flag = err_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
// Self-checking bench for uart_cmd_ctrl. Frames are sent byte by byte with
// random gaps and handshake delays. Expected request lengths, addresses, data
// and error counts are computed from the frame contents and the delays chosen
// by the bench.
// -----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;
    localparam int ADDR_W      = 16;
    localparam int TIMEOUT_CYC = 12000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    uart_cmd_ctrl #(
        .ADDR_W     (ADDR_W),
        .CMD_WR     (8'h55),
        .CMD_RD     (8'hAA),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    int wr_cyc   = 0;
    int rd_cyc   = 0;
    int tx_cnt   = 0;

    // Event counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (bus.err_flag === 1'b1) err_cnt <= err_cnt + 1;
        if (bus.wr_req   === 1'b1) wr_cyc  <= wr_cyc + 1;
        if (bus.rd_req   === 1'b1) rd_cyc  <= rd_cyc + 1;
        if (bus.tx_start === 1'b1) tx_cnt  <= tx_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        err_cnt = 0; wr_cyc = 0; rd_cyc = 0; tx_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.po_flag = 1'b1;
        tick();
        bus.po_flag = 1'b0;
        bus.rx_data = 8'($urandom);
    endtask

    // Four bytes with random gaps between them but none after the last one.
    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] f [4];
        f[0] = b0; f[1] = b1; f[2] = b2; f[3] = b3;
        for (int i = 0; i < 4; i++) begin
            send_byte(f[i]);
            if (i < 3) repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int ack_dly);
        clear_counts();
        send_frame(8'h55, a[15:8], a[7:0], d);
        checks++; if (bus.wr_req !== 1'b1) begin failures++; $display("FAIL wr_req_rise: got %0b want 1", bus.wr_req); end
        checks++; if (bus.wr_addr !== a)   begin failures++; $display("FAIL wr_addr: got %h want %h", bus.wr_addr, a); end
        checks++; if (bus.wr_data !== d)   begin failures++; $display("FAIL wr_data: got %h want %h", bus.wr_data, d); end
        repeat (ack_dly) tick();
        bus.wr_ack = 1'b1;
        tick();
        bus.wr_ack = 1'b0;
        checks++; if (bus.wr_req !== 1'b0) begin failures++; $display("FAIL wr_req_drop: got %0b want 0", bus.wr_req); end
        checks++; if (wr_cyc !== ack_dly + 1) begin failures++; $display("FAIL wr_req_len: got %0d want %0d", wr_cyc, ack_dly + 1); end
        checks++; if (err_cnt !== 0 || rd_cyc !== 0) begin failures++; $display("FAIL wr_side: err=%0d rd=%0d want 0 0", err_cnt, rd_cyc); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wr_busy_end: got %0b want 0", bus.busy); end
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] d,
                           input int ack_dly, input int busy_cyc);
        clear_counts();
        bus.tx_busy = 1'b0;
        send_frame(8'hAA, a[15:8], a[7:0], 8'($urandom));
        checks++; if (bus.rd_req !== 1'b1 || bus.wr_req !== 1'b0) begin failures++; $display("FAIL rd_req_rise: rd=%0b wr=%0b want 1 0", bus.rd_req, bus.wr_req); end
        checks++; if (bus.rd_addr !== a) begin failures++; $display("FAIL rd_addr: got %h want %h", bus.rd_addr, a); end
        repeat (ack_dly) tick();
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        checks++; if (bus.rd_req !== 1'b0 || rd_cyc !== ack_dly + 1) begin failures++; $display("FAIL rd_req_len: req=%0b cyc=%0d want 0 %0d", bus.rd_req, rd_cyc, ack_dly + 1); end
        repeat ($urandom_range(0, 3)) tick();
        bus.tx_busy  = (busy_cyc > 0);
        bus.rd_data  = d;
        bus.rd_valid = 1'b1;
        tick();
        bus.rd_valid = 1'b0;
        bus.rd_data  = 8'($urandom);
        repeat (busy_cyc) tick();
        checks++; if (tx_cnt !== 0 || bus.busy !== 1'b1) begin failures++; $display("FAIL tx_early: tx=%0d busy=%0b want 0 1", tx_cnt, bus.busy); end
        bus.tx_busy = 1'b0;
        tick();
        checks++; if (bus.tx_start !== 1'b1) begin failures++; $display("FAIL tx_start: got %0b want 1", bus.tx_start); end
        checks++; if (bus.tx_data !== d)     begin failures++; $display("FAIL tx_data: got %h want %h", bus.tx_data, d); end
        tick();
        checks++; if (bus.tx_start !== 1'b0 || tx_cnt !== 1 || bus.busy !== 1'b0 || err_cnt !== 0) begin
            failures++; $display("FAIL rd_end: start=%0b pulses=%0d busy=%0b err=%0d want 0 1 0 0", bus.tx_start, tx_cnt, bus.busy, err_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        checks++; if ({bus.wr_req, bus.rd_req, bus.tx_start, bus.err_flag, bus.busy} !== 5'b00000) begin
            failures++; $display("FAIL reset_ctl: got %b want 00000", {bus.wr_req, bus.rd_req, bus.tx_start, bus.err_flag, bus.busy});
        end
        checks++; if (bus.wr_addr !== 16'h0000 || bus.wr_data !== 8'h00 || bus.tx_data !== 8'h00) begin
            failures++; $display("FAIL reset_data: addr=%h data=%h tx=%h want 0", bus.wr_addr, bus.wr_data, bus.tx_data);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write();
        do_write(16'h1234, 8'hA5, 3);
        do_write(16'($urandom), 8'($urandom), 0);
        // Ack already high when the request rises: one-cycle request.
        bus.wr_ack = 1'b1;
        do_write(16'($urandom), 8'($urandom), 0);
    endtask

    task automatic test_read();
        do_read(16'h0010, 8'h3C, 2, 10);
        do_read(16'($urandom), 8'($urandom), 0, 0);
    endtask

    task automatic test_bad_opcode();
        logic [7:0] b;
        b = 8'h77;
        for (int i = 0; i < 2; i++) begin
            clear_counts();
            send_byte(b);
            checks++; if (bus.err_flag !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL bad_op_err: err=%0b busy=%0b want 1 0", bus.err_flag, bus.busy); end
            tick();
            checks++; if (bus.err_flag !== 1'b0 || err_cnt !== 1) begin failures++; $display("FAIL bad_op_pulse: err=%0b pulses=%0d want 0 1", bus.err_flag, err_cnt); end
            do_write(16'h0001, 8'hFF, 1);
            do b = 8'($urandom); while (b == 8'h55 || b == 8'hAA);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] a;
        logic [7:0]  d;
        a = 16'($urandom);
        d = 8'($urandom);
        clear_counts();
        send_frame(8'h55, a[15:8], a[7:0], d);
        repeat (2) tick();
        send_byte(8'($urandom));
        checks++; if (bus.err_flag !== 1'b1 || bus.wr_req !== 1'b1) begin failures++; $display("FAIL ovr_err: err=%0b req=%0b want 1 1", bus.err_flag, bus.wr_req); end
        checks++; if (bus.wr_addr !== a || bus.wr_data !== d) begin failures++; $display("FAIL ovr_hold: addr=%h data=%h want %h %h", bus.wr_addr, bus.wr_data, a, d); end
        tick();
        // Opcode-valued byte coinciding with the ack: transition wins, byte is an overrun.
        bus.wr_ack = 1'b1;
        send_byte(8'h55);
        bus.wr_ack = 1'b0;
        checks++; if (bus.wr_req !== 1'b0 || bus.err_flag !== 1'b1 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL ovr_ack: req=%0b err=%0b busy=%0b want 0 1 0", bus.wr_req, bus.err_flag, bus.busy);
        end
        tick();
        checks++; if (err_cnt !== 2 || wr_cyc !== 5 || bus.wr_addr !== a) begin
            failures++; $display("FAIL ovr_total: err=%0d cyc=%0d addr=%h want 2 5 %h", err_cnt, wr_cyc, bus.wr_addr, a);
        end
    endtask

    task automatic test_reset_midframe();
        clear_counts();
        send_byte(8'h55);
        send_byte(8'h12);
        send_byte(8'h34);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %0b want 1", bus.busy); end
        #1 rst = 1'b0;
        #1;
        checks++; if ({bus.wr_req, bus.rd_req, bus.tx_start, bus.err_flag, bus.busy} !== 5'b00000 ||
                      bus.wr_addr !== 16'h0000 || bus.wr_data !== 8'h00 || bus.tx_data !== 8'h00) begin
            failures++; $display("FAIL mid_reset: ctl=%b addr=%h data=%h tx=%h want 0", {bus.wr_req, bus.rd_req, bus.tx_start, bus.err_flag, bus.busy}, bus.wr_addr, bus.wr_data, bus.tx_data);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        do_write(16'hABCD, 8'h01, 2);
    endtask

`ifdef UART_CMD_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        clear_counts();
        send_byte(8'h55);
        send_byte(8'h12);
        k = 0;
        while (bus.err_flag !== 1'b1 && k < TIMEOUT_CYC + 100) begin
            tick();
            k++;
        end
        checks++; if (k !== TIMEOUT_CYC) begin failures++; $display("FAIL timeout_at: got %0d want %0d", k, TIMEOUT_CYC); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL timeout_busy: got %0b want 0", bus.busy); end
        tick();
        checks++; if (err_cnt !== 1) begin failures++; $display("FAIL timeout_pulses: got %0d want 1", err_cnt); end
        do_write(16'($urandom), 8'($urandom), 1);
    endtask
`else
    task automatic test_stall();
        clear_counts();
        send_byte(8'h55);
        send_byte(8'h12);
        repeat (300) tick();
        checks++; if (bus.busy !== 1'b1 || err_cnt !== 0) begin failures++; $display("FAIL stall: busy=%0b err=%0d want 1 0", bus.busy, err_cnt); end
        #1 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        do_write(16'($urandom), 8'($urandom), 1);
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0: do_write(16'($urandom), 8'($urandom), $urandom_range(0, 4));
                1: do_read(16'($urandom), 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 5));
                default: begin
                    do b = 8'($urandom); while (b == 8'h55 || b == 8'hAA);
                    clear_counts();
                    send_byte(b);
                    tick();
                    checks++; if (err_cnt !== 1 || bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_bad: err=%0d busy=%0b want 1 0", err_cnt, bus.busy); end
                end
            endcase
        end
    endtask

    initial begin
        bus.po_flag  = 1'b0;
        bus.rx_data  = 8'h00;
        bus.wr_ack   = 1'b0;
        bus.rd_ack   = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rd_data  = 8'h00;
        bus.tx_busy  = 1'b0;
        test_reset();
        test_write();
        bus.wr_ack = 1'b0;
        test_read();
        test_bad_opcode();
        test_overrun();
        test_reset_midframe();
`ifdef UART_CMD_TIMEOUT_EN
        test_timeout();
`else
        test_stall();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
